div: RTL and testbench

Multi-cycle 32-bit integer divider serving the execute stage for DIV and DIVU. It is the responder end of the divide request interface. Execute raises a request with operands and a signedness flag, holds it, and waits for `ready_o`. The divider then returns `{remainder, quotient}` for the writes to HI/LO. Implementation is radix-2 restoring division: one quotient bit per cycle, 32 iterations.

---
 rtl/div_pkg.sv | 38 +++
 rtl/div.sv | 174 +++++++++++++++++
 tb/tb_div.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared constants for the multi-cycle divider and its execute-stage client:
//   - divider FSM state encoding
//   - request/result handshake levels
//   - execute ALU op codes that select DIV (signed) or DIVU (unsigned)
//   - a helper that maps an execute op code onto the divider's signed flag
// -----------------------------------------------------------------------------
package div_pkg;

  // Operand width of the integer datapath.
  localparam int DIV_DATA_W = 32;

  // Divider FSM states. The encodings are shared with execute-stage debug
  // views, so they are pinned explicitly.
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Handshake levels seen by the execute stage.
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Execute-stage ALU op codes that issue a divide request.
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // Execute drives signed_div_i from this: only DIV is two's complement.
  function automatic logic is_signed_div(input logic [7:0] aluop);
    return (aluop == EXE_DIV_OP);
  endfunction

endpackage

// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div
// Multi-cycle radix-2 restoring divider for DIV / DIVU. One quotient bit is
// produced per clock, 32 iterations per divide. The execute stage raises
// start_i with the operands, holds it, and waits for ready_o; the divider then
// presents {remainder, quotient} for the HI/LO writes until start_i drops.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   signed_div_i 1 = DIV (two's complement), 0 = DIVU
//   opdata1_i    dividend
//   opdata2_i    divisor
//   start_i      request, held high by execute until the result is consumed
//   annul_i      cancels a pending or in-flight divide (pipeline flush)
//   result_o     {remainder, quotient}; zero whenever ready_o is low
//   ready_o      result valid
//
// Results follow MIPS semantics: the quotient truncates toward zero and the
// remainder takes the sign of the dividend. Division by zero is not trapped;
// it completes with an all-zero result.
// -----------------------------------------------------------------------------
module div
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  // Counter must be able to hold the value DATA_W itself.
  localparam int                CNT_W      = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  LAST_ITER  = CNT_W'(DATA_W);

  div_state_e                   state_reg;
  logic [CNT_W-1:0]             cnt_reg;
  // Working register layout: [2W:W+1] partial remainder, [W:1] dividend bits
  // still to be consumed, with quotient bits shifting in at bit 0.
  logic [2*DATA_W:0]            work_reg;
  logic [DATA_W-1:0]            divisor_reg;
  logic                         rem_neg_reg;   // signed and dividend < 0
  logic                         quo_neg_reg;   // signed and signs differ

  // ---------------------------------------------------------------------------
  // Operand magnitudes at request time. In unsigned mode the raw value is the
  // magnitude. The most negative signed value negates to itself, which read as
  // unsigned is exactly 2^(W-1), so no special case is needed.
  // ---------------------------------------------------------------------------
  logic                         op1_neg;
  logic                         op2_neg;
  logic [DATA_W-1:0]            op1_mag;
  logic [DATA_W-1:0]            op2_mag;

  always_comb begin
    op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    op1_mag = op1_neg ? ({DATA_W{1'b0}} - opdata1_i) : opdata1_i;
    op2_mag = op2_neg ? ({DATA_W{1'b0}} - opdata2_i) : opdata2_i;
  end

  // ---------------------------------------------------------------------------
  // Trial subtraction: the shifted partial remainder against the divisor. The
  // extra top bit is the borrow; set means the divisor did not fit.
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]              trial_diff;

  always_comb begin
    trial_diff = {1'b0, work_reg[2*DATA_W-1:DATA_W]} - {1'b0, divisor_reg};
  end

  // ---------------------------------------------------------------------------
  // Final sign fix-up once all iterations are done.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]            quo_mag;
  logic [DATA_W-1:0]            rem_mag;
  logic [DATA_W-1:0]            quo_final;
  logic [DATA_W-1:0]            rem_final;

  always_comb begin
    quo_mag   = work_reg[DATA_W-1:0];
    rem_mag   = work_reg[2*DATA_W:DATA_W+1];
    quo_final = quo_neg_reg ? ({DATA_W{1'b0}} - quo_mag) : quo_mag;
    rem_final = rem_neg_reg ? ({DATA_W{1'b0}} - rem_mag) : rem_mag;
  end

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers. Outputs are registered here so nothing
  // combinational reaches result_o / ready_o from the inputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= DIV_FREE;
      cnt_reg     <= '0;
      work_reg    <= '0;
      divisor_reg <= '0;
      rem_neg_reg <= 1'b0;
      quo_neg_reg <= 1'b0;
      result_o    <= '0;
      ready_o     <= DIV_RESULT_NOT_READY;
    end else begin
      case (state_reg)
        DIV_FREE: begin
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
          if (start_i == DIV_START && !annul_i) begin
            divisor_reg <= op2_mag;
            rem_neg_reg <= op1_neg;
            quo_neg_reg <= op1_neg ^ op2_neg;
            if (opdata2_i == '0) begin
              state_reg <= DIV_BY_ZERO;
            end else begin
              state_reg <= DIV_ON;
              cnt_reg   <= '0;
              work_reg  <= {{DATA_W{1'b0}}, op1_mag, 1'b0};
            end
          end
        end

        DIV_BY_ZERO: begin
          // The zero result is published by END on its first cycle.
          work_reg  <= '0;
          state_reg <= DIV_END;
        end

        DIV_ON: begin
          if (annul_i) begin
            state_reg <= DIV_FREE;
            cnt_reg   <= '0;
          end else if (cnt_reg != LAST_ITER) begin
            if (trial_diff[DATA_W]) begin
              work_reg <= {work_reg[2*DATA_W-1:0], 1'b0};
            end else begin
              work_reg <= {trial_diff[DATA_W-1:0], work_reg[DATA_W-1:0], 1'b1};
            end
            cnt_reg <= cnt_reg + 1'b1;
          end else begin
            result_o  <= {rem_final, quo_final};
            ready_o   <= DIV_RESULT_READY;
            state_reg <= DIV_END;
            cnt_reg   <= '0;
          end
        end

        DIV_END: begin
          // Arriving from BY_ZERO, ready is still low: raise it with a zero
          // result first so the requester always sees at least one valid cycle.
          if (ready_o == DIV_RESULT_NOT_READY) begin
            result_o <= '0;
            ready_o  <= DIV_RESULT_READY;
          end else if (start_i == DIV_STOP) begin
            result_o  <= '0;
            ready_o   <= DIV_RESULT_NOT_READY;
            state_reg <= DIV_FREE;
          end
        end

        default: begin
          state_reg <= DIV_FREE;
          result_o  <= '0;
          ready_o   <= DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// -----------------------------------------------------------------------------
// tb_div
// Directed bench for the multi-cycle divider. Each step drives a request,
// measures the number of edges until ready_o, and compares the result against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks = 0;
  int n_fail   = 0;

  div #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request now (caller sits 1 time unit after a rising edge), scramble
  // the operands after the accepting edge, and wait for ready_o.
  task automatic run(input string tag, input logic sgn, input logic [31:0] a,
                     input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    int lat;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sgn;
    while (!ready_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, result_o, exp_res);
    $display("txn %s: sgn=%0d a=%h b=%h lat=%0d result=%h", tag, sgn, a, b, lat, result_o);
  endtask

  // Drop start_i and confirm the divider returns to idle on the next edge.
  task automatic release_req(input string tag);
    start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " ready cleared"}, 64'(ready_o), 64'd0);
    check({tag, " result cleared"}, result_o, 64'd0);
  endtask

  initial begin
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;

    // Reset state.
    #2;
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Unsigned 100 / 7, result held while start_i stays high.
    run("udiv 100/7", 1'b0, 32'd100, 32'd7, 34, 64'h00000002_0000000E);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("udiv hold ready", 64'(ready_o), 64'd1);
    check("udiv hold result", result_o, 64'h00000002_0000000E);
    release_req("udiv 100/7");

    // Signed sign combinations.
    run("sdiv -7/2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 34, 64'hFFFFFFFF_FFFFFFFD);
    release_req("sdiv -7/2");
    run("sdiv 7/-2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 34, 64'h00000001_FFFFFFFD);
    release_req("sdiv 7/-2");

    // Divide by zero in both modes.
    run("udiv 5/0", 1'b0, 32'd5, 32'd0, 3, 64'd0);
    release_req("udiv 5/0");
    run("sdiv 5/0", 1'b1, 32'd5, 32'd0, 3, 64'd0);
    release_req("sdiv 5/0");

    // Annul at iteration 10, then a fresh request the following cycle.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd123;
    opdata2_i    = 32'd5;
    start_i      = 1'b1;
    @(posedge clk); #1;            // accepting edge A
    repeat (10) begin
      @(posedge clk); #1;          // A+1 .. A+10
    end
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk); #1;            // annul sampled: back to FREE
    annul_i = 1'b0;
    check("annul ready low", 64'(ready_o), 64'd0);
    run("udiv 1000/10 after annul", 1'b0, 32'd1000, 32'd10, 34, 64'h00000000_00000064);
    release_req("udiv 1000/10");

    // Extremes.
    run("sdiv min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 34, 64'h00000000_80000000);
    release_req("sdiv min/-1");
    run("udiv max/1", 1'b0, 32'hFFFFFFFF, 32'h00000001, 34, 64'h00000000_FFFFFFFF);
    release_req("udiv max/1");

    // Asynchronous reset mid-divide, then a normal request.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd5;
    start_i      = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    check("async rst mid-on ready", 64'(ready_o), 64'd0);
    check("async rst mid-on result", result_o, 64'd0);
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    run("udiv 1000/7 after rst", 1'b0, 32'd1000, 32'd7, 34, 64'h00000006_0000008E);

    // Asynchronous reset while the result is displayed.
    #2 rst = 1'b0;
    #1;
    check("async rst in end ready", 64'(ready_o), 64'd0);
    check("async rst in end result", result_o, 64'd0);
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    run("udiv 9/4", 1'b0, 32'd9, 32'd4, 34, 64'h00000001_00000002);
    release_req("udiv 9/4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
